ysyx_23060208_ifu: RTL and testbench
====================================

# ysyx_23060208_ifu

Instruction fetch unit for the ysyx_23060208 NPC core. It owns the architectural fetch PC, issues word reads to the instruction memory port, and captures the returned instruction. It presents `{pc, inst}` to the decode stage over the valid/allowin handshake. It accepts PC redirects from the execute stage (taken branches, jal/jalr, ecall/mret) and discards any wrong-path fetch that is in flight.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  DATA_WIDTH  fetch address; always equals the PC register.
- imem_resp_valid  in  1  read data valid; single-cycle pulse; ignored outside WAIT.
- imem_resp_data  in  DATA_WIDTH  instruction word.
- redirect_valid  in  1  next-PC override from EXU; single-cycle pulse.
- redirect_pc  in  DATA_WIDTH  override target.
- ifu_to_idu_bus  out  2*DATA_WIDTH  `{pc[63:32], inst[31:0]}`.
- ifu_to_idu_valid  out  1  bus holds a valid instruction.
- idu_allowin  in  1  decode accepts the bus this cycle.

## Operation
- Registers:
  - pc (resets to RESET_PC).
  - inst_r (resets to 0).
  - pc_out_r (resets to 0).
  - drop (resets to 0).
  - state (resets to IDLE).
- FSM states: IDLE, REQ, WAIT, HOLD.
- **IDLE:** lasts one cycle after reset, then goes to REQ.
- **REQ:**
  - imem_req_valid=1 and imem_req_addr=pc.
  - When imem_req_valid && imem_req_ready, go to WAIT.
  - Once asserted, the address stays stable until accepted.
- **WAIT:**
  - On imem_resp_valid with drop=0: inst_r <= resp_data, pc_out_r <= pc, go to HOLD.
  - On imem_resp_valid with drop=1: discard the data, clear drop, go to REQ.
- **HOLD:**
  - ifu_to_idu_valid = !redirect_valid.
  - Transfer occurs when ifu_to_idu_valid && idu_allowin. On transfer, pc <= pc+4 and go to REQ.
- **Redirect:** on redirect_valid, pc <= {redirect_pc[31:2], 2'b00}; the low bits are forced to zero. Effect by state:
  - IDLE: pc updates and the FSM proceeds to REQ as normal.
  - REQ: pc is not updated this cycle, because the address must stay stable. Instead, a pending target register is loaded and drop is set. The outstanding request completes and its response is discarded, then pc <= pending target. Implementation option: hold the target in a pending_pc register and apply it on the drop-response.
  - WAIT: drop is set. If resp_valid arrives in the same cycle, that response is discarded immediately and the FSM goes to REQ with the new pc.
  - HOLD: the held instruction is discarded, no transfer happens that cycle, and the FSM goes to REQ with the new pc.
- A second redirect while drop=1 overwrites the pending target; only the last target is fetched.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0.
- Flushing instructions already accepted by IDU/EXU is outside this block.
- The memory side shares rst; responses are never outstanding across reset.

## Timing
- Reset values:
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - ifu_to_idu_valid=0, ifu_to_idu_bus=0.
- All outputs come from registers or decode of state only; there is no combinational path from any input to imem_req_valid or imem_req_addr.
- The one exception is ifu_to_idu_valid, which is combinationally masked by redirect_valid.
- Minimum fetch loop with zero-wait memory (req_ready=1, response one cycle after acceptance, allowin=1) is 3 cycles per instruction: REQ, WAIT, HOLD.
- First instruction after reset deassert: cycle 0 IDLE, cycle 1 REQ, cycle 2 WAIT, cycle 3 HOLD with valid=1.
- A response is never accepted in the same cycle as its request.
- Redirect in HOLD gives REQ for the new pc on the next cycle.
- Redirect in WAIT costs completion of the old response plus a new REQ.

## Test plan
- **Reset fetch:** rst high for 2 cycles, then low; memory returns 32'h00000413.
  - Required: req_addr=32'h8000_0000 at cycle 1.
  - Required: bus=64'h80000000_00000413 with valid=1 at cycle 3.
- **Sequential stream with backpressure:** hold idu_allowin=0 for 4 cycles during HOLD.
  - Required: the bus stays stable and no new request is issued.
  - After allowin=1: next req_addr=32'h8000_0004.
- **Redirect in WAIT:** pulse redirect_pc=32'h8000_0100 one cycle after request acceptance; memory returns 32'hDEADBEEF.
  - Required: that word never appears with valid.
  - Next req_addr=32'h8000_0100.
- **Redirect in HOLD with idu_allowin=1 in the same cycle:** redirect_pc=32'h8000_0200.
  - Required: ifu_to_idu_valid=0 that cycle.
  - Next req_addr=32'h8000_0200.
- **Redirect in REQ with req_ready=0:**
  - Required: req_addr holds the old value until accepted.
  - Its response is dropped, then req_addr=redirect target.
  - A misaligned target 32'h8000_0302 is fetched as 32'h8000_0300.
- **Wrap:** redirect to 32'hFFFF_FFFC and accept the instruction.
  - Required: next req_addr=32'h0000_0000.

Source files
------------

// File: rtl/ysyx_23060208_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060208_ifu
// Purpose  : Instruction fetch unit of the ysyx_23060208 NPC core. Owns the
//            architectural fetch PC, issues one word read at a time to the
//            instruction memory, captures the returned word and presents
//            {pc, inst} to decode over a valid/allowin handshake. Accepts PC
//            redirects from EXU and discards any wrong-path fetch in flight.
// Ports    : clk, rst                  clock, synchronous active-high reset
//            imem_req_valid/ready/addr fetch request channel (addr == pc)
//            imem_resp_valid/data      single-cycle read response
//            redirect_valid/pc         next-PC override from EXU
//            ifu_to_idu_bus/valid      {pc, inst} to decode
//            idu_allowin               decode accepts the bus this cycle
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060208_ifu #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req_valid,
    input  logic                      imem_req_ready,
    output logic [DATA_WIDTH-1:0]     imem_req_addr,
    input  logic                      imem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     imem_resp_data,
    input  logic                      redirect_valid,
    input  logic [DATA_WIDTH-1:0]     redirect_pc,
    output logic [2*DATA_WIDTH-1:0]   ifu_to_idu_bus,
    output logic                      ifu_to_idu_valid,
    input  logic                      idu_allowin
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0]   inst_r;
    logic [DATA_WIDTH-1:0]   pc_out_r;
    logic [DATA_WIDTH-1:0]   pending_pc;
    logic                    drop;

    // Instruction addresses are word aligned; the two low bits are cleared.
    logic [DATA_WIDTH-1:0]   redirect_target;
    assign redirect_target = redirect_pc & ~DATA_WIDTH'(3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            inst_r     <= '0;
            pc_out_r   <= '0;
            pending_pc <= '0;
            drop       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                    end
                    state <= REQ;
                end
                REQ: begin
                    // The address must not move while the request is
                    // asserted, so the target is parked until the old
                    // request's response has been thrown away.
                    if (redirect_valid) begin
                        pending_pc <= redirect_target;
                        drop       <= 1'b1;
                    end
                    if (imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (redirect_valid) begin
                            // Response and redirect together: the newest
                            // target wins, the word is discarded.
                            pc    <= redirect_target;
                            drop  <= 1'b0;
                            state <= REQ;
                        end else if (drop) begin
                            pc    <= pending_pc;
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            inst_r   <= imem_resp_data;
                            pc_out_r <= pc;
                            state    <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        // A later redirect simply overwrites the parked one.
                        pending_pc <= redirect_target;
                        drop       <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc    <= redirect_target;
                        state <= REQ;
                    end else if (idu_allowin) begin
                        pc    <= pc + DATA_WIDTH'(4);
                        state <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid   = (state == REQ);
    assign imem_req_addr    = pc;
    // A redirect in HOLD kills the held instruction in the same cycle.
    assign ifu_to_idu_valid = (state == HOLD) && !redirect_valid;
    assign ifu_to_idu_bus   = {pc_out_r, inst_r};

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060208_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060208_ifu
// Purpose  : Self-checking bench for ysyx_23060208_ifu. A transaction-level
//            model (expected fetch PC, outstanding fetch, held instruction)
//            is checked against the DUT every cycle, alongside directed
//            scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060208_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [63:0] ifu_to_idu_bus;
    logic        ifu_to_idu_valid;
    logic        idu_allowin;

    ysyx_23060208_ifu #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h8000_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .ifu_to_idu_bus   (ifu_to_idu_bus),
        .ifu_to_idu_valid (ifu_to_idu_valid),
        .idu_allowin      (idu_allowin)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h8000_0000: mem_word = 32'h0000_0413;
            32'h8000_0004: mem_word = 32'hDEAD_BEEF;
            default:       mem_word = a ^ 32'h5A5A_0013;
        endcase
    endfunction

    // ---------------- model state ----------------
    logic [31:0] exp_fetch     = 32'h8000_0000;
    logic        os_valid      = 1'b0;
    logic        os_wrong      = 1'b0;
    logic [31:0] os_addr       = '0;
    logic        held_valid    = 1'b0;
    logic [31:0] held_pc       = '0;
    logic [31:0] held_inst     = '0;
    logic        req_wrong     = 1'b0;
    logic        prev_req_valid = 1'b0;
    logic        prev_req_ready = 1'b0;
    logic [31:0] prev_req_addr = '0;
    logic        saw_bad       = 1'b0;
    int          acc_count     = 0;
    logic [31:0] acc_addr      = '0;

    // ---------------- memory responder state ----------------
    int          mem_lat  = 0;
    int          mem_seen = 0;
    int          mem_cnt  = 0;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;

    // Compare process: samples one time unit before every rising edge.
    initial begin : monitor
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                exp_fetch      = 32'h8000_0000;
                os_valid       = 1'b0;
                os_wrong       = 1'b0;
                held_valid     = 1'b0;
                req_wrong      = 1'b0;
                prev_req_valid = 1'b0;
            end else begin
                if (prev_req_valid && !prev_req_ready) begin
                    chk("req_stable_valid", 64'(imem_req_valid), 64'(1'b1));
                    chk("req_stable_addr", 64'(imem_req_addr), 64'(prev_req_addr));
                end else if (imem_req_valid) begin
                    chk("req_addr", 64'(imem_req_addr), 64'(exp_fetch));
                    chk("req_single", 64'(os_valid || held_valid), 64'(1'b0));
                end
                chk("out_valid", 64'(ifu_to_idu_valid), 64'(held_valid && !redirect_valid));
                if (held_valid && !redirect_valid)
                    chk("out_bus", ifu_to_idu_bus, {held_pc, held_inst});
                if (ifu_to_idu_valid && ifu_to_idu_bus[31:0] == 32'hDEAD_BEEF)
                    saw_bad = 1'b1;

                // effects of the coming edge
                if (held_valid && !redirect_valid && idu_allowin) begin
                    held_valid = 1'b0;
                    exp_fetch  = held_pc + 32'd4;
                end
                if (redirect_valid) begin
                    exp_fetch  = {redirect_pc[31:2], 2'b00};
                    held_valid = 1'b0;
                    if (os_valid) os_wrong = 1'b1;
                    if (imem_req_valid) req_wrong = 1'b1;
                end
                if (imem_resp_valid && os_valid) begin
                    if (!os_wrong) begin
                        held_valid = 1'b1;
                        held_pc    = os_addr;
                        held_inst  = imem_resp_data;
                    end
                    os_valid = 1'b0;
                end
                if (imem_req_valid && imem_req_ready) begin
                    os_valid  = 1'b1;
                    os_addr   = imem_req_addr;
                    os_wrong  = req_wrong;
                    req_wrong = 1'b0;
                    acc_addr  = imem_req_addr;
                    acc_count++;
                end
                prev_req_valid = imem_req_valid;
                prev_req_ready = imem_req_ready;
                prev_req_addr  = imem_req_addr;
            end
        end
    end

    // Memory: answers each accepted request mem_lat cycles after the
    // cycle following acceptance, with a one-cycle pulse.
    initial begin : memory
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (rst) begin
                mem_busy = 1'b0;
                mem_seen = acc_count;
            end else begin
                if (acc_count != mem_seen) begin
                    mem_seen = acc_count;
                    mem_busy = 1'b1;
                    mem_cnt  = mem_lat;
                    mem_addr = acc_addr;
                end
                if (mem_busy) begin
                    if (mem_cnt == 0) begin
                        imem_resp_valid = 1'b1;
                        imem_resp_data  = mem_word(mem_addr);
                        mem_busy        = 1'b0;
                    end else begin
                        mem_cnt--;
                    end
                end
            end
        end
    end

    // Callers are at negedge+1.
    task automatic wait_req(input logic [31:0] exp, input string name);
        int n = 0;
        while (!imem_req_valid && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_valid"}, 64'(imem_req_valid), 64'(1'b1));
        chk(name, 64'(imem_req_addr), 64'(exp));
    endtask

    task automatic wait_valid(input logic [63:0] exp, input string name);
        int n = 0;
        while (!ifu_to_idu_valid && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_valid"}, 64'(ifu_to_idu_valid), 64'(1'b1));
        chk(name, ifu_to_idu_bus, exp);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, fails so far %0d", fails);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [63:0] bus0;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        idu_allowin    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // reset state
        @(negedge clk); #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'(1'b0));
        chk("rst_req_addr", 64'(imem_req_addr), 64'(32'h8000_0000));
        chk("rst_out_valid", 64'(ifu_to_idu_valid), 64'(1'b0));
        chk("rst_bus", ifu_to_idu_bus, 64'h0);

        // reset fetch: cycle 0 IDLE, 1 REQ, 2 WAIT, 3 HOLD
        @(negedge clk); rst = 1'b0; #1;
        chk("c0_req_valid", 64'(imem_req_valid), 64'(1'b0));
        @(negedge clk); #1;
        chk("c1_req_valid", 64'(imem_req_valid), 64'(1'b1));
        chk("c1_req_addr", 64'(imem_req_addr), 64'(32'h8000_0000));
        @(negedge clk); #1;
        chk("c2_req_valid", 64'(imem_req_valid), 64'(1'b0));
        @(negedge clk); #1;
        chk("c3_out_valid", 64'(ifu_to_idu_valid), 64'(1'b1));
        chk("c3_bus", ifu_to_idu_bus, 64'h80000000_00000413);
        bus0    = ifu_to_idu_bus;
        mem_lat = 2;

        // backpressure: four stalled HOLD cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("bp_bus", ifu_to_idu_bus, 64'h80000000_00000413);
            chk("bp_valid", 64'(ifu_to_idu_valid), 64'(1'b1));
            chk("bp_no_req", 64'(imem_req_valid), 64'(1'b0));
        end
        idu_allowin = 1'b1;
        wait_req(32'h8000_0004, "seq_next");

        // redirect one cycle after acceptance, response arrives later
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        wait_req(32'h8000_0100, "wait_redir");

        // redirect in HOLD with allowin=1
        wait_valid({32'h8000_0100, mem_word(32'h8000_0100)}, "fetch_100");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        #1;
        chk("hold_redir_valid", 64'(ifu_to_idu_valid), 64'(1'b0));
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        wait_req(32'h8000_0200, "hold_redir");

        // redirects in REQ while the memory stalls; the last one wins
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0400;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("req_redir_hold1", 64'(imem_req_addr), 64'(32'h8000_0200));
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0302;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("req_redir_hold2", 64'(imem_req_addr), 64'(32'h8000_0200));
        chk("req_redir_hold2_valid", 64'(imem_req_valid), 64'(1'b1));
        @(negedge clk);
        imem_req_ready = 1'b1;
        mem_lat        = 0;
        #1;
        chk("req_redir_hold3", 64'(imem_req_addr), 64'(32'h8000_0200));
        @(negedge clk); #1;
        wait_req(32'h8000_0300, "req_redir_align");

        // wrap-around
        wait_valid({32'h8000_0300, mem_word(32'h8000_0300)}, "fetch_300");
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        wait_req(32'hFFFF_FFFC, "wrap_req");
        wait_valid({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)}, "wrap_inst");
        wait_req(32'h0000_0000, "wrap_next");

        // redirect in WAIT coinciding with the response
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0500;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("wait_same_req_valid", 64'(imem_req_valid), 64'(1'b1));
        chk("wait_same_req_addr", 64'(imem_req_addr), 64'(32'h8000_0500));
        wait_valid({32'h8000_0500, mem_word(32'h8000_0500)}, "fetch_500");

        repeat (4) @(negedge clk);
        chk("no_deadbeef", 64'(saw_bad), 64'(1'b0));
        chk("first_bus", bus0, 64'h80000000_00000413);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
